// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared constants and state encoding for the matmul result
//               path (reader, row/col counter, operand feeder).
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BUS_WIDTH  = 64;
    localparam int DEF_MAX_DIM    = DEF_BUS_WIDTH / DEF_DATA_WIDTH;

    // Row/column index width; covers matrices up to 4x4.
    localparam int DIM_W          = 2;

    // A C element is the full-precision product width of two operands.
    localparam int ELEM_MULT      = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_rc_counter.sv
`default_nettype none
// ============================================================================
// Module      : matmul_rc_counter
// Description : Row-major row/column walker bounded by inclusive limits
//               n_max/m_max. load_zero wins over advance. last flags the
//               final (n_max, m_max) position.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_rc_counter
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_zero,
    input  logic             advance,
    input  logic [DIM_W-1:0] n_max,
    input  logic [DIM_W-1:0] m_max,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);

    // Walk columns first, wrapping into the next row at m_max.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (load_zero) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col < m_max) begin
                col <= col + DIM_W'(1);
            end else begin
                col <= '0;
                row <= row + DIM_W'(1);
            end
        end
    end

    assign last = (row == n_max) && (col == m_max);

endmodule : matmul_rc_counter
`default_nettype wire

// File: rtl/matmul_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_reader
// Description : Snapshots the systolic array's C matrix on a completion
//               pulse and streams the valid (N+1)x(M+1) elements row-major
//               over a valid/ready bus, sign-extended to the bus width.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_reader
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          done_i,
    input  logic [DIM_W-1:0]                              N_i,
    input  logic [DIM_W-1:0]                              M_i,
    input  logic [MAX_DIM*MAX_DIM*ELEM_MULT*DATA_WIDTH-1:0] c_matrix_i,
    output logic [BUS_WIDTH-1:0]                          data_o,
    output logic                                          valid_o,
    input  logic                                          ready_i,
    output logic [DIM_W-1:0]                              row_o,
    output logic [DIM_W-1:0]                              col_o,
    output logic                                          last_o,
    output logic                                          busy_o,
    output logic                                          drop_o
);

    localparam int               ELEM_W  = ELEM_MULT * DATA_WIDTH;
    localparam int               FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;
    localparam logic [DIM_W-1:0] MAX_IDX = DIM_W'(MAX_DIM - 1);

    if (BUS_WIDTH < ELEM_W) begin : g_bus_width_check
        $error("matmul_result_reader: BUS_WIDTH must be >= 2*DATA_WIDTH");
    end
    if ((MAX_DIM > 4) || (MAX_DIM < 1)) begin : g_max_dim_check
        $error("matmul_result_reader: MAX_DIM must be in 1..4");
    end

    rd_state_t          state;
    rd_state_t          state_next;
    logic               capture;
    logic               advance;
    logic               load_zero;
    logic               drop_next;
    logic [FLAT_W-1:0]  c_shadow;
    logic [DIM_W-1:0]   n_shadow;
    logic [DIM_W-1:0]   m_shadow;
    logic [DIM_W-1:0]   n_clamped;
    logic [DIM_W-1:0]   m_clamped;
    logic [DIM_W-1:0]   row;
    logic [DIM_W-1:0]   col;
    logic               cnt_last;
    logic [ELEM_W-1:0]  element;
    logic               streaming;

    // Dimensions beyond the physical array are pinned to the array edge so
    // the element mux never addresses outside the snapshot.
    assign n_clamped = (N_i > MAX_IDX) ? MAX_IDX : N_i;
    assign m_clamped = (M_i > MAX_IDX) ? MAX_IDX : M_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control: capture, counter steering, drop detection.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        load_zero  = 1'b0;
        drop_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (done_i) begin
                    capture    = 1'b1;
                    load_zero  = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (ready_i && cnt_last) begin
                    // Final beat accepted; a coincident done_i chains the
                    // next matrix with no idle gap.
                    load_zero = 1'b1;
                    if (done_i) begin
                        capture = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (ready_i) begin
                    advance = 1'b1;
                end
                drop_next = done_i && !capture;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shadow copy of the result matrix and its active dimensions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_shadow <= '0;
            n_shadow <= '0;
            m_shadow <= '0;
        end else if (capture) begin
            c_shadow <= c_matrix_i;
            n_shadow <= n_clamped;
            m_shadow <= m_clamped;
        end
    end

    // Registered one-cycle pulse for each ignored completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_o <= 1'b0;
        end else begin
            drop_o <= drop_next;
        end
    end

    matmul_rc_counter u_rc_counter (
        .clk       (clk_i),
        .rst       (rst_i),
        .load_zero (load_zero),
        .advance   (advance),
        .n_max     (n_shadow),
        .m_max     (m_shadow),
        .row       (row),
        .col       (col),
        .last      (cnt_last)
    );

    // Select the shadow element addressed by the current row/col.
    always_comb begin
        element = '0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                if ((row == DIM_W'(r)) && (col == DIM_W'(c))) begin
                    element = c_shadow[(r*MAX_DIM + c)*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    assign streaming = (state == ST_STREAM);
    assign valid_o   = streaming;
    assign busy_o    = streaming;
    assign last_o    = streaming && cnt_last;
    assign row_o     = row;
    assign col_o     = col;
    assign data_o    = streaming ? BUS_WIDTH'($signed(element)) : '0;

endmodule : matmul_result_reader
`default_nettype wire

// File: tb/tb_matmul_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_result_reader
// Description : Self-checking bench for matmul_result_reader using a
//               row-major expected-beat queue built from the snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_result_reader;

    localparam int MD = 2;
    localparam int EW = 64;
    localparam int CW = MD*MD*EW;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          done;
    logic [1:0]    n_in;
    logic [1:0]    m_in;
    logic [CW-1:0] c_in;
    logic [63:0]   data;
    logic          valid;
    logic          ready;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
    logic          busy;
    logic          drop;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    matmul_result_reader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .done_i     (done),
        .N_i        (n_in),
        .M_i        (m_in),
        .c_matrix_i (c_in),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .row_o      (row),
        .col_o      (col),
        .last_o     (last),
        .busy_o     (busy),
        .drop_o     (drop)
    );

    function automatic logic [CW-1:0] rand_mat();
        logic [CW-1:0] m;
        for (int i = 0; i < CW/32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    // Expected stream: every element with r<=N, c<=M in row-major order.
    task automatic build_exp(input logic [CW-1:0] cm, input int nr, input int nc);
        exp_q.delete();
        for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c <= nc; c++) begin
                beat_t b;
                b.d = cm[(r*MD + c)*EW +: EW];
                b.r = 2'(r);
                b.c = 2'(c);
                b.l = (r == nr) && (c == nc);
                exp_q.push_back(b);
            end
        end
    endtask

    // Called and returns at posedge+1; scrambles the inputs afterwards.
    task automatic pulse_done(input logic [CW-1:0] cm, input logic [1:0] nn, input logic [1:0] mm);
        done = 1'b1; c_in = cm; n_in = nn; m_in = mm;
        @(posedge clk); #1;
        done = 1'b0; c_in = rand_mat(); n_in = 2'($urandom); m_in = 2'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (last  !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", last); end
        checks++; if (drop  !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
        checks++; if (data  !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
        checks++; if ({row, col} !== 4'h0) begin errors++; $display("FAIL reset_rowcol: got %0d,%0d want 0,0", row, col); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_release_idle: got v=%b b=%b want 0 0", valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_drain();
        logic [CW-1:0] cm;
        beat_t e;
        cm = '0;
        for (int i = 0; i < 4; i++) cm[i*EW +: EW] = 64'(i + 1);
        build_exp(cm, 1, 1);
        ready = 1'b1;
        pulse_done(cm, 2'd1, 2'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, busy, last, row, col, data} !== {1'b1, 1'b1, e.l, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL full_drain beat%0d: got v=%b b=%b l=%b r=%0d c=%0d d=%h want v=1 b=1 l=%b r=%0d c=%0d d=%h",
                         k, valid, busy, last, row, col, data, e.l, e.r, e.c, e.d);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if ({valid, busy, last} !== 3'b000) begin errors++; $display("FAIL full_drain_idle: got v=%b b=%b l=%b want 0 0 0", valid, busy, last); end
        @(posedge clk); #1;
    endtask

    task automatic test_1x2_negative();
        logic [CW-1:0] cm;
        beat_t e;
        cm = rand_mat();
        cm[1*EW +: EW] = 64'hFFFF_FFFF_FFFF_FFFB;
        build_exp(cm, 0, 1);
        ready = 1'b1;
        pulse_done(cm, 2'd0, 2'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, busy, last, row, col, data} !== {1'b1, 1'b1, e.l, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL one_by_two beat%0d: got v=%b l=%b r=%0d c=%0d d=%h want v=1 l=%b r=%0d c=%0d d=%h",
                         k, valid, last, row, col, data, e.l, e.r, e.c, e.d);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL one_by_two_idle: got v=%b b=%b want 0 0", valid, busy); end
        @(posedge clk); #1;
    endtask

    // Drains the queued stream with the given ready policy; stalled beats
    // must keep presenting the head of the queue.
    task automatic test_backpressure();
        logic [CW-1:0] cm;
        bit pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int cyc;
        cm = rand_mat();
        build_exp(cm, 1, 1);
        ready = 1'b0;
        pulse_done(cm, 2'd1, 2'd1);
        cyc = 0;
        ready = pat[0];
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            checks++;
            if ({valid, busy, last, row, col, data} !== {1'b1, 1'b1, exp_q[0].l, exp_q[0].r, exp_q[0].c, exp_q[0].d}) begin
                errors++;
                $display("FAIL backpressure cyc%0d: got v=%b l=%b r=%0d c=%0d d=%h want v=1 l=%b r=%0d c=%0d d=%h",
                         cyc, valid, last, row, col, data, exp_q[0].l, exp_q[0].r, exp_q[0].c, exp_q[0].d);
            end
            if (ready) void'(exp_q.pop_front());
            @(posedge clk); #1;
            cyc++;
            ready = (cyc < 5) ? pat[cyc] : 1'($urandom_range(0, 1));
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL backpressure_timeout: %0d beats left want 0", exp_q.size()); end
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL backpressure_idle: got v=%b b=%b want 0 0", valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_streams();
        logic [CW-1:0] cm;
        int nr, nc, cyc;
        for (int it = 0; it < 6; it++) begin
            cm = rand_mat();
            nr = $urandom_range(0, 1);
            nc = $urandom_range(0, 1);
            build_exp(cm, nr, nc);
            pulse_done(cm, 2'(nr), 2'(nc));
            cyc = 0;
            ready = 1'($urandom_range(0, 1));
            while (exp_q.size() > 0 && cyc < 60) begin
                @(negedge clk);
                checks++;
                if ({valid, last, row, col, data} !== {1'b1, exp_q[0].l, exp_q[0].r, exp_q[0].c, exp_q[0].d}) begin
                    errors++;
                    $display("FAIL random_stream it%0d cyc%0d: got v=%b l=%b r=%0d c=%0d d=%h want v=1 l=%b r=%0d c=%0d d=%h",
                             it, cyc, valid, last, row, col, data, exp_q[0].l, exp_q[0].r, exp_q[0].c, exp_q[0].d);
                end
                if (ready) void'(exp_q.pop_front());
                @(posedge clk); #1;
                cyc++;
                ready = 1'($urandom_range(0, 1));
            end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_stream_timeout it%0d: %0d beats left want 0", it, exp_q.size()); end
            @(negedge clk);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL random_stream_idle it%0d: got v=%b want 0", it, valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] ca, cb, cd;
        beat_t e;
        ca = rand_mat(); cb = rand_mat(); cd = rand_mat();
        build_exp(ca, 1, 1);
        ready = 1'b1;
        pulse_done(ca, 2'd1, 2'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin done = 1'b1; c_in = cd; n_in = 2'd0; m_in = 2'd0; end
            if (k == 3) begin done = 1'b1; c_in = cb; n_in = 2'd1; m_in = 2'd1; end
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, last, row, col, data} !== {1'b1, e.l, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL midstream_done beat%0d: got v=%b l=%b r=%0d c=%0d d=%h want v=1 l=%b r=%0d c=%0d d=%h",
                         k, valid, last, row, col, data, e.l, e.r, e.c, e.d);
            end
            checks++;
            if (drop !== (k == 2)) begin errors++; $display("FAIL drop_pulse beat%0d: got %b want %b", k, drop, (k == 2)); end
            @(posedge clk); #1;
            done = 1'b0; c_in = rand_mat(); n_in = 2'($urandom); m_in = 2'($urandom);
        end
        build_exp(cb, 1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, drop, last, row, col, data} !== {1'b1, 1'b0, e.l, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL back_to_back beat%0d: got v=%b drop=%b l=%b r=%0d c=%0d d=%h want v=1 drop=0 l=%b r=%0d c=%0d d=%h",
                         k, valid, drop, last, row, col, data, e.l, e.r, e.c, e.d);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL back_to_back_idle: got v=%b b=%b want 0 0", valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        logic [CW-1:0] ca, cb;
        beat_t e;
        ca = rand_mat(); cb = rand_mat();
        build_exp(ca, 1, 1);
        ready = 1'b1;
        pulse_done(ca, 2'd1, 2'd1);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) rst = 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, row, col, data} !== {1'b1, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL pre_reset beat%0d: got v=%b r=%0d c=%0d d=%h want v=1 r=%0d c=%0d d=%h",
                         k, valid, row, col, data, e.r, e.c, e.d);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, busy, last, drop, row, col, data} !== {4'b0000, 2'd0, 2'd0, 64'h0}) begin
            errors++;
            $display("FAIL reset_abort: got v=%b b=%b l=%b drop=%b r=%0d c=%0d d=%h want all 0",
                     valid, busy, last, drop, row, col, data);
        end
        @(posedge clk); #1;
        build_exp(cb, 1, 1);
        pulse_done(cb, 2'd1, 2'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({valid, last, row, col, data} !== {1'b1, e.l, e.r, e.c, e.d}) begin
                errors++;
                $display("FAIL post_reset beat%0d: got v=%b l=%b r=%0d c=%0d d=%h want v=1 l=%b r=%0d c=%0d d=%h",
                         k, valid, last, row, col, data, e.l, e.r, e.c, e.d);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got v=%b want 0", valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; ready = 1'b0;
        n_in = '0; m_in = '0; c_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_full_drain();
        test_1x2_negative();
        test_backpressure();
        test_random_streams();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_matmul_result_reader
`default_nettype wire
